dcache_write_buffer: RTL and testbench
======================================

// Module: dcache_write_buffer
// PURPOSE
//  Posted-store FIFO between the MEM-stage D-cache (write-through) and main memory (memory4c).
//  Absorbs stores so MEM does not stall for each memory write; drains in order when memory is free.
//  Exposes a block-address match so the cache fill FSM defers a miss fill until older stores to that block land.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  ADDR_W  16  byte address width
//  DATA_W  16  word width
//  BLK_LSB 4   low bit of block address (16-byte / 8-word blocks)
// PORTS
//  clk          in   1       system clock; all state changes on posedge
//  rst_n        in   1       asynchronous, active-low reset
//  st_valid     in   1       MEM stage presents a store this cycle
//  st_addr      in   ADDR_W  store byte address (bit 0 ignored)
//  st_data      in   DATA_W  store data
//  st_stall     out  1       buffer full; store not accepted; MEM must hold
//  mem_wr_req   out  1       head entry ready to write to memory
//  mem_wr_addr  out  ADDR_W  head entry address
//  mem_wr_data  out  DATA_W  head entry data
//  mem_wr_ack   in   1       memory accepted head write this cycle
//  fill_busy    in   1       fill FSM owns memory; no write is requested
//  chk_addr     in   ADDR_W  miss address to check
//  chk_hit      out  1       some valid entry shares chk_addr's block
//  empty        out  1       no valid entries
//  count        out  clog2(DEPTH)+1  valid entry count
// BEHAVIOUR
//  Reset (rst_n=0, async): all entries invalid, rd/wr ptrs=0, count=0, empty=1, st_stall=0, mem_wr_req=0,
//    mem_wr_addr/data=0. Pending stores are discarded, even mid-drain.
//  Storage: circular FIFO of {addr,data}; rd_ptr/wr_ptr wrap mod DEPTH; count disambiguates full/empty.
//  st_stall = (count==DEPTH) & st_valid; comb from registered count. No bypass when full, even if a pop
//    occurs the same cycle.
//  Push: st_valid & ~full. If st_addr[ADDR_W-1:1] equals the youngest entry's word address and that entry
//    is not being popped this cycle, merge: overwrite its data; count unchanged. Otherwise append at wr_ptr.
//  Issue: mem_wr_req = ~empty & ~fill_busy; addr/data = head entry (comb from registered state).
//  Pop: mem_wr_req & mem_wr_ack -> rd_ptr+1, count-1 at the next edge. Ack while req=0 is ignored.
//  Simultaneous push+pop: count unchanged; both ptrs advance. If count==1, a word match against the head
//    being popped appends instead of merging.
//  Latency: store accepted at edge N is eligible for mem_wr_req in cycle N+1 (no comb st->mem path).
//  chk_hit: comb OR over valid entries of entry.addr[ADDR_W-1:BLK_LSB]==chk_addr[ADDR_W-1:BLK_LSB].
//    Uses registered entries only; a store pushed this cycle is visible next cycle.
//    Fill FSM rule: it must not raise fill_busy for an address while chk_hit=1; it waits for the drain.
//  fill_busy asserted mid-request: mem_wr_req drops the same cycle; head is retained and reissued later.
//  Ordering: writes reach memory in program order, except that merged same-word stores collapse into one.
// STRUCTURE
//  Shared package wb_pkg: DEPTH, ADDR_W, DATA_W, BLK_LSB defaults and the ptr width localparam.
//  One sub-module, wb_block_match: DEPTH-way block-address comparator; inputs entry addrs and valid vector,
//    output hit. FIFO pointers, count and merge logic stay in dcache_write_buffer.
// TESTING
//  1 Reset: rst_n=0 mid-drain with 3 entries -> count=0, empty=1, mem_wr_req=0, async (before next edge).
//  2 Fill: 4 stores 0x0010..0x0016, ack=0 -> count=4; 5th st_valid -> st_stall=1 and entry not stored.
//  3 Drain order: ack every cycle -> mem_wr_addr sequence 0x0010,0x0012,0x0014,0x0016; empty after 4 acks.
//  4 Merge: store 0x0020=0xAAAA then 0x0020=0xBBBB, no ack -> count=1; on ack, memory receives 0xBBBB once.
//  5 Match: entry at 0x0034; chk_addr=0x003E -> chk_hit=1; chk_addr=0x0040 -> chk_hit=0.
//  6 Contention: fill_busy=1 with count=2 -> mem_wr_req=0, no pop on ack; fill_busy=0 -> head reissued.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults for the D-cache posted-store write buffer.
package wb_pkg;
    localparam int WB_DEPTH   = 4;
    localparam int WB_ADDR_W  = 16;
    localparam int WB_DATA_W  = 16;
    localparam int WB_BLK_LSB = 4;
    localparam int WB_PTR_W   = $clog2(WB_DEPTH);
endpackage

// File: rtl/wb_block_match.sv
// wb_block_match: flags any valid entry sharing the checked address's cache block.
module wb_block_match #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 16,
    parameter int BLK_LSB = 4
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [DEPTH-1:0]             valid,
    input  logic [ADDR_W-1:0]            chk_addr,
    output logic                         hit
);
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            hit = hit | (valid[i] & (addrs[i][ADDR_W-1:BLK_LSB] == chk_addr[ADDR_W-1:BLK_LSB]));
    end
endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: in-order posted-store FIFO between a write-through D-cache and memory,
// merging back-to-back stores to the same word and exposing a block match for miss fills.
module dcache_write_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH   = WB_DEPTH,
    parameter int ADDR_W  = WB_ADDR_W,
    parameter int DATA_W  = WB_DATA_W,
    parameter int BLK_LSB = WB_BLK_LSB,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_stall,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_wr_ack,
    input  logic              fill_busy,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_hit,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);
    logic [ADDR_W-1:0]             addr_q [DEPTH];
    logic [DATA_W-1:0]             data_q [DEPTH];
    logic [PTR_W-1:0]              rd_ptr, wr_ptr, yng;
    logic [DEPTH-1:0][ADDR_W-1:0]  addr_v;
    logic [DEPTH-1:0]              valid;
    logic                          full, push, pop, merge, append;

    assign full        = count == CNT_W'(DEPTH);
    assign empty       = count == '0;
    assign st_stall    = full & st_valid;
    assign mem_wr_req  = ~empty & ~fill_busy;
    assign mem_wr_addr = empty ? '0 : addr_q[rd_ptr];
    assign mem_wr_data = empty ? '0 : data_q[rd_ptr];
    assign pop         = mem_wr_req & mem_wr_ack;
    assign push        = st_valid & ~full;
    assign yng         = wr_ptr - 1'b1;
    // The youngest entry is only unmergeable when it is also the head leaving this cycle.
    assign merge       = push & ~empty & (addr_q[yng][ADDR_W-1:1] == st_addr[ADDR_W-1:1])
                       & ~(pop & (count == CNT_W'(1)));
    assign append      = push & ~merge;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_valid
            assign valid[i]  = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
            assign addr_v[i] = addr_q[i];
        end
    endgenerate

    wb_block_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BLK_LSB(BLK_LSB)) u_match (
        .addrs(addr_v), .valid(valid), .chk_addr(chk_addr), .hit(chk_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                addr_q[k] <= '0;
                data_q[k] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (append) begin
                addr_q[wr_ptr] <= {st_addr[ADDR_W-1:1], 1'b0};
                data_q[wr_ptr] <= st_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end else if (merge) begin
                data_q[yng] <= st_data;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(append) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed and random stimulus against a queue model of the write buffer.
module tb_dcache_write_buffer;
    logic        clk, rst_n, st_valid, st_stall, mem_wr_req, mem_wr_ack, fill_busy, chk_hit, empty;
    logic [15:0] st_addr, st_data, mem_wr_addr, mem_wr_data, chk_addr;
    logic [2:0]  count;
    int          total = 0, bad = 0;

    typedef struct { logic [15:0] a; logic [15:0] d; } ent_t;
    ent_t q[$];

    dcache_write_buffer dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_stall(st_stall), .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack), .fill_busy(fill_busy),
        .chk_addr(chk_addr), .chk_hit(chk_hit), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered list of pending words; merge only into the youngest surviving entry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else begin
            automatic int  n   = q.size();
            automatic bit  pp  = (n > 0) && !fill_busy && mem_wr_ack;
            automatic bit  psh = st_valid && (n < 4);
            automatic bit  mrg = psh && (n > 0) && (q[n-1].a[15:1] == st_addr[15:1]) && !(pp && n == 1);
            automatic ent_t e;
            if (pp) void'(q.pop_front());
            if (mrg) begin
                e = q.pop_back();
                e.d = st_data;
                q.push_back(e);
            end else if (psh) q.push_back('{{st_addr[15:1], 1'b0}, st_data});
        end
    end

    always @(negedge clk) begin
        automatic int n = q.size();
        automatic bit hit = 1'b0;
        foreach (q[k]) if (q[k].a[15:4] == chk_addr[15:4]) hit = 1'b1;
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("st_stall", 32'(st_stall), 32'(n == 4 && st_valid));
        chk("mem_wr_req", 32'(mem_wr_req), 32'(n > 0 && !fill_busy));
        chk("chk_hit", 32'(chk_hit), 32'(hit));
        if (n > 0) begin
            chk("mem_wr_addr", 32'(mem_wr_addr), 32'(q[0].a));
            chk("mem_wr_data", 32'(mem_wr_data), 32'(q[0].d));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        st_valid = 1'b1; st_addr = a; st_data = d;
        tick();
        st_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        mem_wr_ack = 1'b0; fill_busy = 1'b0; chk_addr = 16'hFFF0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_req", 32'(mem_wr_req), 0);
        chk("rst_addr", 32'(mem_wr_addr), 0);
        chk("rst_stall", 32'(st_stall), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // fill to capacity, then a fifth store must stall
        for (int k = 0; k < 4; k++) store(16'h0010 + 16'(2 * k), 16'h1000 + 16'(k));
        chk("fill_count", 32'(count), 4);
        st_valid = 1'b1; st_addr = 16'h0018; st_data = 16'h1004;
        #1 chk("fill_stall", 32'(st_stall), 1);
        tick();
        st_valid = 1'b0;
        chk("fill_held", 32'(count), 4);
        // drain in order
        mem_wr_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("drain_addr", 32'(mem_wr_addr), 32'(16'h0010 + 16'(2 * k)));
            tick();
        end
        mem_wr_ack = 1'b0;
        chk("drain_empty", 32'(empty), 1);
        // same-word merge
        store(16'h0020, 16'hAAAA);
        store(16'h0021, 16'hBBBB);
        chk("merge_count", 32'(count), 1);
        mem_wr_ack = 1'b1;
        chk("merge_data", 32'(mem_wr_data), 32'hBBBB);
        tick();
        mem_wr_ack = 1'b0;
        chk("merge_once", 32'(count), 0);
        // block match
        store(16'h0034, 16'h3434);
        chk_addr = 16'h003E;
        #1 chk("match_hit", 32'(chk_hit), 1);
        chk_addr = 16'h0040;
        #1 chk("match_miss", 32'(chk_hit), 0);
        mem_wr_ack = 1'b1; tick(); mem_wr_ack = 1'b0;
        // fill contention
        store(16'h0050, 16'h5050);
        store(16'h0060, 16'h6060);
        fill_busy = 1'b1; mem_wr_ack = 1'b1;
        #1 chk("busy_req", 32'(mem_wr_req), 0);
        tick();
        chk("busy_hold", 32'(count), 2);
        fill_busy = 1'b0;
        #1 chk("reissue_req", 32'(mem_wr_req), 1);
        chk("reissue_addr", 32'(mem_wr_addr), 32'h0050);
        tick(); tick();
        mem_wr_ack = 1'b0;
        chk("contend_empty", 32'(empty), 1);
        // asynchronous reset mid-drain
        store(16'h0070, 16'h0001);
        store(16'h0080, 16'h0002);
        store(16'h0090, 16'h0003);
        chk("pre_rst_count", 32'(count), 3);
        mem_wr_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_req", 32'(mem_wr_req), 0);
        mem_wr_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        // random traffic over a small word pool so merges and block hits occur
        for (int c = 0; c < 3000; c++) begin
            st_valid   = ($urandom_range(0, 99) < 60);
            st_addr    = 16'(($urandom_range(0, 3) << 4) | ($urandom_range(0, 1) << 1) | $urandom_range(0, 1));
            st_data    = 16'($urandom);
            mem_wr_ack = ($urandom_range(0, 99) < 45);
            fill_busy  = ($urandom_range(0, 99) < 20);
            chk_addr   = 16'($urandom_range(0, 79));
            tick();
        end
        st_valid = 1'b0;
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
